axi_lite_slave_regfile: RTL and testbench
=========================================

AXI_LITE_SLAVE_REGFILE -- requirements
Module: axi_lite_slave_regfile

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width.
REQ-003 SHALL have parameter VERSION, default 32'h0001_0000, the read-only value at offset 0x10.
REQ-004 ACLK  in  1  single clock; all state changes on the rising edge.
REQ-005 ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-006 S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address; S_AXI_AWPROT in 3, ignored.
REQ-007 S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1  write address handshake.
REQ-008 S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WVALID in 1 / S_AXI_WREADY out 1  write data channel.
REQ-009 S_AXI_BRESP out 2; S_AXI_BVALID out 1 / S_AXI_BREADY in 1  write response channel.
REQ-010 S_AXI_ARADDR in C_S_AXI_ADDR_WIDTH; S_AXI_ARPROT in 3, ignored; S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1  read address channel.
REQ-011 S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1 / S_AXI_RREADY in 1  read data channel.
REQ-012 REG0..REG3  out  32 each  current register contents, for downstream fabric.

Function
REQ-013 Address map, decoded on ADDR[4:2] with ADDR[1:0] ignored: 0x00..0x0C REG0..REG3 (RW), 0x10 VERSION (RO), 0x14..0x1C unmapped.
REQ-014 Write FSM SHALL have states W_IDLE and W_RESP; AW and W are captured independently, in either order or in the same cycle.
REQ-015 In W_IDLE, AWREADY=1 until AW is captured and WREADY=1 until W is captured; each drops the cycle after its handshake.
REQ-016 On the edge following the later of the two handshakes (edge E+1): commit the write, set BVALID=1, enter W_RESP.
REQ-017 Commit to REGn: update only the bytes whose WSTRB bit is 1; WSTRB=0 leaves the register unchanged and returns OKAY.
REQ-018 A write to 0x10 or an unmapped address SHALL change no state and return BRESP=2'b10 (SLVERR); otherwise BRESP=2'b00.
REQ-019 In W_RESP, BVALID and BRESP hold stable until BREADY=1; on that edge clear BVALID and return to W_IDLE; AWREADY=WREADY=0 throughout W_RESP.
REQ-020 Read path: ARREADY=1 whenever RVALID=0; AR handshake at edge E SHALL load RDATA/RRESP and set RVALID at edge E+1.
REQ-021 RVALID, RDATA and RRESP hold stable until RREADY=1; RVALID clears on that edge; ARREADY returns high the following cycle.
REQ-022 An unmapped read SHALL return RDATA=0 and RRESP=SLVERR; a read of 0x10 returns VERSION with OKAY.
REQ-023 Read and write paths are independent; if a write commit and an AR handshake to the same register fall on the same edge, RDATA SHALL carry the pre-write value.
REQ-024 At most one outstanding write and one outstanding read at any time; no ID or burst support.

Reset
REQ-025 While ARESETN=0, immediately and asynchronously: REG0..REG3=0; BVALID=RVALID=0; AWREADY=WREADY=ARREADY=0; BRESP=RRESP=0; RDATA=0; FSM in W_IDLE with no captured AW/W.
REQ-026 After ARESETN deasserts, AWREADY, WREADY and ARREADY SHALL rise on the first rising edge.
REQ-027 Reset mid-transaction SHALL discard any partially captured AW/W and any pending B/R response, with no register update.

Verification
REQ-028 Write 0x1, 0x2, 0x3, 0x4 to 0x00/0x04/0x08/0x0C with WSTRB=0xF, then read the same addresses -> each BRESP=OKAY, reads return 1, 2, 3, 4, and REG0..REG3 match.
REQ-029 W presented 3 cycles before AW, then AW before W, then both in the same cycle, writing 0xA5A5A5A5 to 0x04 -> one B response each, BVALID exactly one cycle after the later handshake, REG1=0xA5A5A5A5.
REQ-030 REG2=0x11223344, then write 0xFFFFFFFF with WSTRB=4'b0101 -> REG2=0x11FF33FF; then WSTRB=0 -> REG2 unchanged, BRESP=OKAY.
REQ-031 Write to 0x10 and 0x18 -> BRESP=SLVERR and VERSION unchanged; read 0x10 -> 0x00010000/OKAY; read 0x1C -> 0/SLVERR.
REQ-032 Hold BREADY and RREADY low for 5 cycles -> BVALID/RVALID and payloads remain stable; no new AW/W/AR accepted until each response is taken.
REQ-033 Assert ARESETN=0 between the W and AW handshakes of a write to 0x00 (REG0=0x5) -> REG0=0, no BVALID, and the next full write completes normally.

Source files
------------

// File: rtl/axi_lite_slave_regfile.sv
// axi_lite_slave_regfile: AXI4-Lite slave with four RW registers and a read-only version word
module axi_lite_slave_regfile #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [31:0] VERSION            = 32'h0001_0000
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   REG0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   REG1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   REG2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   REG3
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    w_state_e w_state_q, w_state_d;
    logic live_q, live_d;
    logic aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [2:0] aw_idx_q, aw_idx_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW/8-1:0] wstrb_q, wstrb_d;
    logic [3:0][DW-1:0] regs_q, regs_d;
    logic bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DW-1:0] rdata_q, rdata_d, wmask;
    logic [2:0] ar_idx;
    logic unused_ok;
    // live_q keeps every ready low until the first edge after reset release
    assign S_AXI_AWREADY = live_q && w_state_q == W_IDLE && !aw_done_q;
    assign S_AXI_WREADY  = live_q && w_state_q == W_IDLE && !w_done_q;
    assign S_AXI_ARREADY = live_q && !rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign {REG3, REG2, REG1, REG0} = regs_q;
    assign ar_idx = S_AXI_ARADDR[4:2];
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
    always_comb begin
        wmask = '0;
        for (int b = 0; b < DW / 8; b++) wmask[8*b +: 8] = {8{wstrb_q[b]}};
    end
    always_comb begin
        w_state_d = w_state_q;
        live_d    = 1'b1;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        aw_idx_d  = aw_idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        regs_d    = regs_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            aw_done_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[4:2];
        end
        if (S_AXI_WVALID && S_AXI_WREADY) begin
            w_done_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
        end
        if (w_state_q == W_IDLE && aw_done_q && w_done_q) begin
            if (!aw_idx_q[2]) regs_d[aw_idx_q[1:0]] = (regs_q[aw_idx_q[1:0]] & ~wmask) | (wdata_q & wmask);
            bresp_d   = aw_idx_q[2] ? 2'b10 : 2'b00;
            bvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            w_state_d = W_RESP;
        end else if (w_state_q == W_RESP && S_AXI_BREADY) begin
            bvalid_d  = 1'b0;
            w_state_d = W_IDLE;
        end
        // reads sample regs_q, so a same-edge commit is not yet visible
        if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            rvalid_d = 1'b1;
            rdata_d  = ar_idx[2] ? (ar_idx == 3'd4 ? VERSION : '0) : regs_q[ar_idx[1:0]];
            rresp_d  = (ar_idx[2] && ar_idx[1:0] != 2'd0) ? 2'b10 : 2'b00;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_q <= W_IDLE;
            live_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            regs_q    <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            live_q    <= live_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            aw_idx_q  <= aw_idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            regs_q    <= regs_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end
endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// tb_axi_lite_slave_regfile: randomized and directed bench against a transaction-level register model
module tb_axi_lite_slave_regfile;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [4:0] awaddr = '0, araddr = '0;
    logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0] wstrb = '0;
    logic awready, wready, bvalid, arready, rvalid;
    logic [1:0] bresp, rresp;
    logic [31:0] rdata, reg0, reg1, reg2, reg3;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    axi_lite_slave_regfile dut (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .REG0(reg0), .REG1(reg1), .REG2(reg2), .REG3(reg3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one pending write slot, one pending read response
    logic [31:0] m_reg [4];
    bit m_live, m_aw, m_w, m_bv, m_rv;
    int m_aidx;
    logic [31:0] m_wd, m_rdata, m_mask;
    logic [3:0] m_ws;
    logic [1:0] m_bresp, m_rresp;
    bit e_awready, e_wready, e_arready;
    assign e_awready = m_live && !m_bv && !m_aw;
    assign e_wready  = m_live && !m_bv && !m_w;
    assign e_arready = m_live && !m_rv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_live = 0; m_aw = 0; m_w = 0; m_bv = 0; m_rv = 0;
            m_bresp = 0; m_rresp = 0; m_rdata = 0;
            for (int i = 0; i < 4; i++) m_reg[i] = 0;
        end else begin
            bit awr, wr, arr;
            int ri;
            awr = e_awready; wr = e_wready; arr = e_arready;
            if (arvalid && arr) begin
                ri = int'(araddr) / 4;
                m_rv = 1;
                m_rdata = ri < 4 ? m_reg[ri] : (ri == 4 ? 32'h0001_0000 : 32'h0);
                m_rresp = ri <= 4 ? 2'b00 : 2'b10;
            end else if (m_rv && rready) m_rv = 0;
            if (m_aw && m_w) begin
                m_mask = {{8{m_ws[3]}}, {8{m_ws[2]}}, {8{m_ws[1]}}, {8{m_ws[0]}}};
                if (m_aidx < 4) m_reg[m_aidx] = (m_reg[m_aidx] & ~m_mask) | (m_wd & m_mask);
                m_bresp = m_aidx < 4 ? 2'b00 : 2'b10;
                m_bv = 1; m_aw = 0; m_w = 0;
            end else begin
                if (m_bv && bready) m_bv = 0;
                if (awvalid && awr) begin m_aw = 1; m_aidx = int'(awaddr) / 4; end
                if (wvalid && wr) begin m_w = 1; m_wd = wdata; m_ws = wstrb; end
            end
            m_live = 1;
        end
    end

    always @(negedge clk) begin
        chk("awready", 32'(awready), 32'(e_awready));
        chk("wready", 32'(wready), 32'(e_wready));
        chk("arready", 32'(arready), 32'(e_arready));
        chk("bvalid", 32'(bvalid), 32'(m_bv));
        chk("rvalid", 32'(rvalid), 32'(m_rv));
        chk("reg0", reg0, m_reg[0]);
        chk("reg1", reg1, m_reg[1]);
        chk("reg2", reg2, m_reg[2]);
        chk("reg3", reg3, m_reg[3]);
        if (m_bv) chk("bresp", 32'(bresp), 32'(m_bresp));
        if (m_rv) begin
            chk("rdata", rdata, m_rdata);
            chk("rresp", 32'(rresp), 32'(m_rresp));
        end
    end

    task automatic write_txn(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int hold, output logic [1:0] rsp);
        bit aw_ok = 0, w_ok = 0;
        int cyc = 0;
        while (!(aw_ok && w_ok) && cyc < 50) begin
            awvalid = !aw_ok && cyc >= aw_dly; awaddr = a;
            wvalid = !w_ok && cyc >= w_dly; wdata = d; wstrb = s;
            @(negedge clk);
            if (awvalid && awready) aw_ok = 1;
            if (wvalid && wready) w_ok = 1;
            @(posedge clk); #1;
            cyc++;
        end
        awvalid = 0; wvalid = 0;
        chk("wr_handshake", 32'(aw_ok && w_ok), 32'd1);
        @(negedge clk); chk("b_not_early", 32'(bvalid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("b_latency", 32'(bvalid), 32'd1);
        repeat (hold) begin @(posedge clk); #1; @(negedge clk); end
        rsp = bresp; bready = 1;
        @(posedge clk); #1;
        bready = 0;
    endtask

    task automatic read_txn(input logic [4:0] a, input int ar_dly, input int hold,
                            output logic [31:0] d, output logic [1:0] rsp);
        bit ok = 0;
        int cyc = 0;
        repeat (ar_dly) begin @(posedge clk); #1; end
        araddr = a; arvalid = 1;
        while (!ok && cyc < 50) begin
            @(negedge clk); ok = arready;
            @(posedge clk); #1;
            cyc++;
        end
        arvalid = 0;
        chk("rd_handshake", 32'(ok), 32'd1);
        @(negedge clk); chk("r_latency", 32'(rvalid), 32'd1);
        repeat (hold) begin @(posedge clk); #1; @(negedge clk); end
        d = rdata; rsp = rresp; rready = 1;
        @(posedge clk); #1;
        rready = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] r, rr;
        logic [31:0] d;
        #2;
        chk("rst_awready", 32'(awready), 0); chk("rst_wready", 32'(wready), 0);
        chk("rst_arready", 32'(arready), 0); chk("rst_bvalid", 32'(bvalid), 0);
        chk("rst_rvalid", 32'(rvalid), 0); chk("rst_rdata", rdata, 0);
        chk("rst_bresp", 32'(bresp), 0); chk("rst_rresp", 32'(rresp), 0);
        chk("rst_reg0", reg0, 0); chk("rst_reg3", reg3, 0);
        #21 rst_n = 1;
        @(posedge clk); #1;
        chk("post_rst_awready", 32'(awready), 1); chk("post_rst_wready", 32'(wready), 1);
        chk("post_rst_arready", 32'(arready), 1);
        for (int i = 0; i < 4; i++) begin
            write_txn(5'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0, r);
            chk("seq_bresp", 32'(r), 0);
        end
        for (int i = 0; i < 4; i++) begin
            read_txn(5'(i * 4), 0, 0, d, r);
            chk("seq_rdata", d, 32'(i + 1));
            chk("seq_rresp", 32'(r), 0);
        end
        chk("seq_reg0", reg0, 1); chk("seq_reg1", reg1, 2); chk("seq_reg2", reg2, 3); chk("seq_reg3", reg3, 4);
        write_txn(5'h04, 32'hA5A5_A5A5, 4'hF, 3, 0, 0, r); chk("w_first_bresp", 32'(r), 0);
        write_txn(5'h04, 32'h0, 4'hF, 0, 0, 0, r);
        write_txn(5'h04, 32'hA5A5_A5A5, 4'hF, 0, 3, 0, r); chk("aw_first_bresp", 32'(r), 0);
        chk("aw_first_reg1", reg1, 32'hA5A5_A5A5);
        write_txn(5'h04, 32'h0, 4'hF, 0, 0, 0, r);
        write_txn(5'h04, 32'hA5A5_A5A5, 4'hF, 0, 0, 0, r); chk("same_bresp", 32'(r), 0);
        chk("order_reg1", reg1, 32'hA5A5_A5A5);
        write_txn(5'h08, 32'h1122_3344, 4'hF, 0, 0, 0, r);
        write_txn(5'h08, 32'hFFFF_FFFF, 4'b0101, 0, 0, 0, r);
        chk("strb_reg2", reg2, 32'h11FF_33FF);
        write_txn(5'h08, 32'hFFFF_FFFF, 4'b0000, 1, 0, 0, r);
        chk("strb0_reg2", reg2, 32'h11FF_33FF); chk("strb0_bresp", 32'(r), 0);
        write_txn(5'h10, 32'hDEAD_0000, 4'hF, 0, 0, 0, r); chk("ro_bresp", 32'(r), 2);
        write_txn(5'h18, 32'hDEAD_0001, 4'hF, 0, 0, 0, r); chk("unmapped_bresp", 32'(r), 2);
        read_txn(5'h10, 0, 0, d, r); chk("version_rdata", d, 32'h0001_0000); chk("version_rresp", 32'(r), 0);
        read_txn(5'h1C, 0, 0, d, r); chk("unmapped_rdata", d, 0); chk("unmapped_rresp", 32'(r), 2);
        fork
            write_txn(5'h0C, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, r);
            read_txn(5'h0C, 1, 0, d, rr);
        join
        chk("collide_rdata", d, 32'h4); chk("collide_reg3", reg3, 32'hDEAD_BEEF);
        fork
            write_txn(5'h00, 32'hCAFE_0001, 4'hF, 0, 0, 5, r);
            read_txn(5'h04, 0, 5, d, rr);
        join
        chk("hold_bresp", 32'(r), 0); chk("hold_rdata", d, 32'hA5A5_A5A5); chk("hold_reg0", reg0, 32'hCAFE_0001);
        for (int n = 0; n < 80; n++) begin
            int op;
            logic [4:0] wa, ra;
            op = int'($urandom_range(0, 2));
            wa = 5'($urandom_range(0, 31));
            ra = 5'($urandom_range(0, 31));
            if (op == 0)
                write_txn(wa, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r);
            else if (op == 1)
                read_txn(ra, 0, int'($urandom_range(0, 3)), d, rr);
            else
                fork
                    write_txn(wa, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), r);
                    read_txn(ra, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), d, rr);
                join
        end
        write_txn(5'h00, 32'h5, 4'hF, 0, 0, 0, r);
        begin
            bit ok = 0;
            int cyc = 0;
            wvalid = 1; wdata = 32'h5A; wstrb = 4'hF;
            while (!ok && cyc < 50) begin
                @(negedge clk); ok = wready;
                @(posedge clk); #1;
                cyc++;
            end
            wvalid = 0;
            chk("mid_w_handshake", 32'(ok), 1);
        end
        #2 rst_n = 0;
        #1;
        chk("mid_rst_reg0", reg0, 0); chk("mid_rst_bvalid", 32'(bvalid), 0);
        chk("mid_rst_awready", 32'(awready), 0); chk("mid_rst_wready", 32'(wready), 0);
        chk("mid_rst_arready", 32'(arready), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk); #1;
        chk("mid_post_awready", 32'(awready), 1); chk("mid_post_wready", 32'(wready), 1);
        write_txn(5'h00, 32'h77, 4'hF, 0, 4, 0, r);
        chk("mid_next_bresp", 32'(r), 0); chk("mid_next_reg0", reg0, 32'h77);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
